// File: rtl/sopc_run_ctrl.sv
// Run controller for the minimal SOPC: sequences per-core reset release after a start
// request, bounds the run by a cycle budget and detects program halt from stalled PCs.
module sopc_run_ctrl #(
    parameter int NUM_CORES       = 2,
    parameter int PC_W            = 32,
    parameter int RST_HOLD_CYCLES = 10,
    parameter int STAGGER         = 2,
    parameter int RUN_CYCLES      = 50,
    parameter int STALL_LIMIT     = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_CORES*PC_W-1:0] pc_i,
    output logic [NUM_CORES-1:0]      core_rst_o,
    output logic                      run_o,
    output logic                      done_o,
    output logic                      timeout_o,
    output logic [31:0]               cycle_cnt_o,
    output logic [2:0]                state_o
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_HOLD    = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_HALTED  = 3'd3;
    localparam logic [2:0] S_TIMEOUT = 3'd4;

    localparam int              SW        = $clog2(STALL_LIMIT + 1);
    localparam logic [SW-1:0]   STALL_MAX = SW'(STALL_LIMIT);
    localparam logic [31:0]     HOLD_LAST = 32'(RST_HOLD_CYCLES - 1);
    localparam logic [31:0]     RUN_LAST  = (RUN_CYCLES == 0) ? 32'd0 : 32'(RUN_CYCLES - 1);

    logic [2:0]           state_q, state_d;
    logic [31:0]          hold_q, hold_d;
    logic [31:0]          cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 tmo_q, tmo_d;
    logic                 run_q, run_d;
    logic [NUM_CORES-1:0] core_rst_q, core_rst_d;
    logic [NUM_CORES-1:0] seen_q, seen_d;
    logic [SW-1:0]        stall_q [NUM_CORES];
    logic [SW-1:0]        stall_d [NUM_CORES];
    logic [PC_W-1:0]      prev_q  [NUM_CORES];
    logic [PC_W-1:0]      prev_d  [NUM_CORES];

    logic all_stalled;
    logic halt_now;
    logic budget_hit;

    // Halt needs every core released and every stall counter pinned at the limit.
    always_comb begin
        all_stalled = 1'b1;
        for (int k = 0; k < NUM_CORES; k++) begin
            if (stall_q[k] != STALL_MAX) all_stalled = 1'b0;
        end
        halt_now   = (state_q == S_RUN) && (core_rst_q == '0) && all_stalled;
        budget_hit = (RUN_CYCLES != 0) && (cnt_q == RUN_LAST);
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        tmo_d   = tmo_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_HOLD;
                    hold_d  = 32'd0;
                end
            end
            S_HOLD: begin
                if (hold_q == HOLD_LAST) begin
                    state_d = S_RUN;
                    cnt_d   = 32'd0;
                end else begin
                    hold_d = hold_q + 32'd1;
                end
            end
            S_RUN: begin
                if (halt_now) begin
                    state_d = S_HALTED;
                    done_d  = 1'b1;
                end else if (budget_hit) begin
                    state_d = S_TIMEOUT;
                    tmo_d   = 1'b1;
                end else if (cnt_q != 32'hFFFF_FFFF) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            S_HALTED, S_TIMEOUT: begin
                if (start) begin
                    state_d = S_HOLD;
                    hold_d  = 32'd0;
                    cnt_d   = 32'd0;
                    done_d  = 1'b0;
                    tmo_d   = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Release schedule is a pure function of the next cycle count.
        run_d = (state_d == S_RUN);
        for (int k = 0; k < NUM_CORES; k++) begin
            core_rst_d[k] = !(run_d && (cnt_d >= 32'(k * STAGGER)));
        end
    end

    // A core's first released cycle only captures its PC; comparisons start one cycle later.
    always_comb begin
        for (int k = 0; k < NUM_CORES; k++) begin
            stall_d[k] = stall_q[k];
            prev_d[k]  = prev_q[k];
            seen_d[k]  = seen_q[k];
            if (state_q != S_RUN) begin
                stall_d[k] = '0;
                seen_d[k]  = 1'b0;
            end else if (!core_rst_q[k]) begin
                prev_d[k] = pc_i[k*PC_W +: PC_W];
                seen_d[k] = 1'b1;
                if (seen_q[k]) begin
                    if (pc_i[k*PC_W +: PC_W] == prev_q[k]) begin
                        if (stall_q[k] != STALL_MAX) stall_d[k] = stall_q[k] + SW'(1);
                    end else begin
                        stall_d[k] = '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            hold_q     <= 32'd0;
            cnt_q      <= 32'd0;
            done_q     <= 1'b0;
            tmo_q      <= 1'b0;
            run_q      <= 1'b0;
            core_rst_q <= '1;
            seen_q     <= '0;
            for (int k = 0; k < NUM_CORES; k++) begin
                stall_q[k] <= '0;
                prev_q[k]  <= '0;
            end
        end else begin
            state_q    <= state_d;
            hold_q     <= hold_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            tmo_q      <= tmo_d;
            run_q      <= run_d;
            core_rst_q <= core_rst_d;
            seen_q     <= seen_d;
            for (int k = 0; k < NUM_CORES; k++) begin
                stall_q[k] <= stall_d[k];
                prev_q[k]  <= prev_d[k];
            end
        end
    end

    assign core_rst_o  = core_rst_q;
    assign run_o       = run_q;
    assign done_o      = done_q;
    assign timeout_o   = tmo_q;
    assign cycle_cnt_o = cnt_q;
    assign state_o     = state_q;

endmodule
